// File: rtl/alu_acc.sv
// alu_acc: bus-fed accumulator with single-cycle LOAD/ADD/SUB/CLR/INC and shift-add MUL (ALU_ACC_SAT_EN adds saturation).
// Latency: single-cycle ops update ac at the start edge with done the next cycle; MUL has done in cycle MUL_W+1.
// Backpressure: busy is high during MUL and start is ignored then (no queueing); start alongside done is accepted.
module alu_acc #(
  parameter int DATA_W = 16,
  parameter int MUL_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [2:0]        alu_op,
  input  logic              start,
  output logic [DATA_W-1:0] ac,
  output logic              busy,
  output logic              done,
  output logic              c_flag,
  output logic              z_flag
);

  localparam int PROD_W = 2 * MUL_W;
  localparam int CNT_W  = $clog2(MUL_W) + 1;

  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_INC  = 3'd6;

  typedef enum logic {IDLE, MUL} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   ac_nxt;
  logic                c_nxt, busy_nxt, done_nxt;
  logic [PROD_W-1:0]   mcand, mcand_nxt;
  logic [MUL_W-1:0]    mplier, mplier_nxt;
  logic [PROD_W-1:0]   prod, prod_nxt, prod_step;
  logic [CNT_W-1:0]    count, count_nxt;

  // Extra top bit carries the carry-out (ADD/INC) or borrow (SUB).
  logic [DATA_W:0]     add_sum, sub_diff, inc_sum;
  logic [DATA_W-1:0]   add_res, sub_res, inc_res;

  assign add_sum  = {1'b0, ac} + {1'b0, bus_in};
  assign sub_diff = {1'b0, ac} - {1'b0, bus_in};
  assign inc_sum  = {1'b0, ac} + {{DATA_W{1'b0}}, 1'b1};

`ifdef ALU_ACC_SAT_EN
  assign add_res = add_sum[DATA_W]  ? {DATA_W{1'b1}} : add_sum[DATA_W-1:0];
  assign sub_res = sub_diff[DATA_W] ? {DATA_W{1'b0}} : sub_diff[DATA_W-1:0];
  assign inc_res = inc_sum[DATA_W]  ? {DATA_W{1'b1}} : inc_sum[DATA_W-1:0];
`else
  assign add_res = add_sum[DATA_W-1:0];
  assign sub_res = sub_diff[DATA_W-1:0];
  assign inc_res = inc_sum[DATA_W-1:0];
`endif

  assign prod_step = prod + (mplier[0] ? mcand : {PROD_W{1'b0}});
  assign z_flag    = (ac == {DATA_W{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ac     <= '0;
      c_flag <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      ac     <= ac_nxt;
      c_flag <= c_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      prod   <= prod_nxt;
      count  <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ac_nxt     = ac;
    c_nxt      = c_flag;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    prod_nxt   = prod;
    count_nxt  = count;
    case (state)
      IDLE: begin
        if (start) begin
          done_nxt = (alu_op != OP_MUL);
          case (alu_op)
            OP_LOAD: ac_nxt = bus_in;
            OP_ADD: begin
              ac_nxt = add_res;
              c_nxt  = add_sum[DATA_W];
            end
            OP_SUB: begin
              ac_nxt = sub_res;
              c_nxt  = sub_diff[DATA_W];
            end
            OP_CLR: begin
              ac_nxt = '0;
              c_nxt  = 1'b0;
            end
            OP_INC: begin
              ac_nxt = inc_res;
              c_nxt  = inc_sum[DATA_W];
            end
            OP_MUL: begin
              mcand_nxt  = PROD_W'(ac[MUL_W-1:0]);
              mplier_nxt = bus_in[MUL_W-1:0];
              prod_nxt   = '0;
              count_nxt  = '0;
              busy_nxt   = 1'b1;
              state_nxt  = MUL;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        prod_nxt   = prod_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + CNT_W'(1);
        // Final step writes the completed product straight into ac.
        if (count == CNT_W'(MUL_W - 1)) begin
          ac_nxt    = DATA_W'(prod_step);
          c_nxt     = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_alu_acc.sv
// Directed self-checking bench for alu_acc; expected values are hand-computed constants.
module tb_alu_acc;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] SUB  = 3'd3;
  localparam logic [2:0] MULT = 3'd4;
  localparam logic [2:0] CLR  = 3'd5;
  localparam logic [2:0] INC  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic [2:0]  alu_op;
  logic        start;
  logic [15:0] ac;
  logic        busy, done, c_flag, z_flag;

  int checks = 0;
  int errors = 0;
  int ndone;

  alu_acc dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_in (bus_in),
    .alu_op (alu_op),
    .start  (start),
    .ac     (ac),
    .busy   (busy),
    .done   (done),
    .c_flag (c_flag),
    .z_flag (z_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] d);
    start  = 1'b1;
    alu_op = op;
    bus_in = d;
    tick();
    start  = 1'b0;
    alu_op = NOP;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    alu_op = NOP;
    bus_in = 16'h0000;
    #22;
    check("rst_ac", ac, 16'h0000);
    check("rst_busy", {15'b0, busy}, 16'h0000);
    check("rst_done", {15'b0, done}, 16'h0000);
    check("rst_c", {15'b0, c_flag}, 16'h0000);
    check("rst_z", {15'b0, z_flag}, 16'h0001);
    tick();
    rst_n = 1'b1;
    tick();

    // LOAD
    issue(LOAD, 16'h1234);
    check("load_ac", ac, 16'h1234);
    check("load_done", {15'b0, done}, 16'h0001);
    check("load_busy", {15'b0, busy}, 16'h0000);
    check("load_z", {15'b0, z_flag}, 16'h0000);
    tick();
    check("load_done_drop", {15'b0, done}, 16'h0000);
    check("load_ac_hold", ac, 16'h1234);

    // ADD with carry out
    issue(LOAD, 16'hFFFF);
    issue(ADD, 16'h0002);
`ifdef ALU_ACC_SAT_EN
    check("add_ac", ac, 16'hFFFF);
`else
    check("add_ac", ac, 16'h0001);
`endif
    check("add_c", {15'b0, c_flag}, 16'h0001);
    check("add_done", {15'b0, done}, 16'h0001);

    // LOAD keeps c_flag, then SUB with borrow, then INC
    issue(LOAD, 16'h0005);
    check("load_keeps_c", {15'b0, c_flag}, 16'h0001);
    issue(SUB, 16'h0007);
`ifdef ALU_ACC_SAT_EN
    check("sub_ac", ac, 16'h0000);
`else
    check("sub_ac", ac, 16'hFFFE);
`endif
    check("sub_c", {15'b0, c_flag}, 16'h0001);
    issue(INC, 16'h0000);
`ifdef ALU_ACC_SAT_EN
    check("inc_ac", ac, 16'h0001);
`else
    check("inc_ac", ac, 16'hFFFF);
`endif
    check("inc_c", {15'b0, c_flag}, 16'h0000);

    // INC with carry, then CLR
    issue(LOAD, 16'hFFFF);
    issue(INC, 16'h0000);
`ifdef ALU_ACC_SAT_EN
    check("inc_wrap_ac", ac, 16'hFFFF);
`else
    check("inc_wrap_ac", ac, 16'h0000);
`endif
    check("inc_wrap_c", {15'b0, c_flag}, 16'h0001);
    issue(CLR, 16'h5555);
    check("clr_ac", ac, 16'h0000);
    check("clr_c", {15'b0, c_flag}, 16'h0000);
    check("clr_z", {15'b0, z_flag}, 16'h0001);

    // Set c_flag, load operand, NOP
    issue(LOAD, 16'hFFFF);
    issue(INC, 16'h0000);
    issue(LOAD, 16'h00FF);
    issue(NOP, 16'h1234);
    check("nop_ac", ac, 16'h00FF);
    check("nop_c", {15'b0, c_flag}, 16'h0001);
    check("nop_done", {15'b0, done}, 16'h0001);

    // MUL 0xFF * 0xFF, bus_in dropped after the start edge
    issue(MULT, 16'h00FF);
    bus_in = 16'h0000;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("mul_busy_%0d", i), {15'b0, busy}, 16'h0001);
      check($sformatf("mul_done_%0d", i), {15'b0, done}, 16'h0000);
      tick();
    end
    check("mul_busy_end", {15'b0, busy}, 16'h0000);
    check("mul_done", {15'b0, done}, 16'h0001);
    check("mul_ac", ac, 16'hFE01);
    check("mul_c", {15'b0, c_flag}, 16'h0000);
    tick();
    check("mul_done_drop", {15'b0, done}, 16'h0000);

    // Same multiply with a LOAD start during busy cycle 3
    issue(LOAD, 16'h00FF);
    issue(MULT, 16'h00FF);
    bus_in = 16'h0000;
    ndone = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done) ndone++;
      if (cyc == 3) begin
        start  = 1'b1;
        alu_op = LOAD;
        bus_in = 16'hAAAA;
      end else begin
        start  = 1'b0;
        alu_op = NOP;
      end
      if (cyc == 4) check("ign_busy_c4", {15'b0, busy}, 16'h0001);
      if (cyc == 9) check("ign_done_c9", {15'b0, done}, 16'h0001);
      tick();
    end
    check("ign_ac", ac, 16'hFE01);
    check("ign_ndone", 16'(ndone), 16'h0001);

    // MUL 0x12 * 0x34 aborted by reset in busy cycle 4
    issue(LOAD, 16'h0012);
    issue(MULT, 16'h0034);
    ndone = 0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_busy_c4", {15'b0, busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("abort_ac", ac, 16'h0000);
    check("abort_busy", {15'b0, busy}, 16'h0000);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (done) ndone++;
      tick();
    end
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_ndone", 16'(ndone), 16'h0000);
    check("abort_ac_after", ac, 16'h0000);
    issue(LOAD, 16'h1111);
    check("post_rst_ac", ac, 16'h1111);
    check("post_rst_done", {15'b0, done}, 16'h0001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
